// File: rtl/randomizer_pkg.sv
// Shared constants and the single-bit Fibonacci LFSR step for the parallel randomizer.
package randomizer_pkg;

  localparam int unsigned LFSR_W       = 15;
  localparam int unsigned DATA_W       = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK     = 15'h0003;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'h4A80;

  // Step vectors are carried at a fixed maximum width so one function serves any LFSR_W.
  localparam int unsigned LFSR_MAX_W = 32;

  typedef logic [LFSR_MAX_W-1:0] lfsr_vec_t;

  typedef struct packed {
    lfsr_vec_t state;
    logic      fb;
  } lfsr_step_t;

  function automatic lfsr_step_t lfsr_step(input lfsr_vec_t   state,
                                           input lfsr_vec_t   mask,
                                           input int unsigned width);
    lfsr_step_t r;
    r.fb    = ^(state & mask);
    r.state = (state >> 1) | (lfsr_vec_t'(r.fb) << (width - 1));
    return r;
  endfunction

endpackage

// File: rtl/randomizer_if.sv
// Streaming handshake bundle: input beat channel and output beat channel.
interface randomizer_if #(
  parameter int unsigned DATA_W = randomizer_pkg::DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/randomizer_lfsr_core.sv
// Combinational DATA_W-step LFSR unroll; bit 0 of the data is scrambled first.
module randomizer_lfsr_core #(
  parameter int unsigned       LFSR_W   = randomizer_pkg::LFSR_W,
  parameter int unsigned       DATA_W   = randomizer_pkg::DATA_W,
  parameter logic [LFSR_W-1:0] TAP_MASK = randomizer_pkg::TAP_MASK
) (
  input  logic [LFSR_W-1:0] i_state,
  input  logic [DATA_W-1:0] i_data,
  output logic [LFSR_W-1:0] o_state,
  output logic [DATA_W-1:0] o_data
);

  import randomizer_pkg::*;

  lfsr_vec_t  w_state;
  lfsr_step_t w_step;

  always_comb begin
    w_state = lfsr_vec_t'(i_state);
    w_step  = '0;
    o_data  = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      w_step    = lfsr_step(w_state, lfsr_vec_t'(TAP_MASK), LFSR_W);
      o_data[k] = i_data[k] ^ w_step.fb;
      w_state   = w_step.state;
    end
    o_state = w_state[LFSR_W-1:0];
  end

endmodule

// File: rtl/randomizer_par.sv
// Parallel energy-dispersal randomizer with valid/ready streaming, frame-end reseed and bypass.
// Optional zero-seed guard: RANDOMIZER_ZERO_GUARD_EN.
module randomizer_par #(
  parameter int unsigned       LFSR_W       = randomizer_pkg::LFSR_W,
  parameter int unsigned       DATA_W       = randomizer_pkg::DATA_W,
  parameter logic [LFSR_W-1:0] TAP_MASK     = randomizer_pkg::TAP_MASK,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = randomizer_pkg::DEFAULT_SEED
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              enable,
  randomizer_if.slave       bus,
  output logic              seed_err
);

  import randomizer_pkg::*;

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] r_seed;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;

  logic [LFSR_W-1:0] w_core_state;
  logic [DATA_W-1:0] w_core_data;
  logic [LFSR_W-1:0] w_load_val;
  logic              w_in_ready;
  logic              w_accept;

  assign w_in_ready    = !load && (!r_out_valid || bus.out_ready);
  assign w_accept      = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

  randomizer_lfsr_core #(
    .LFSR_W   (LFSR_W),
    .DATA_W   (DATA_W),
    .TAP_MASK (TAP_MASK)
  ) u_core (
    .i_state (r_state),
    .i_data  (bus.in_data),
    .o_state (w_core_state),
    .o_data  (w_core_data)
  );

`ifdef RANDOMIZER_ZERO_GUARD_EN
  logic r_seed_err;

  assign w_load_val = (seed == '0) ? DEFAULT_SEED : seed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_seed_err <= 1'b0;
    end else if (load && (seed == '0)) begin
      r_seed_err <= 1'b1;
    end
  end

  assign seed_err = r_seed_err;
`else
  assign w_load_val = seed;
  assign seed_err   = 1'b0;
`endif

  // load wins over frame-end reseed; a last beat reseeds even when bypassed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DEFAULT_SEED;
      r_seed  <= DEFAULT_SEED;
    end else if (load) begin
      r_state <= w_load_val;
      r_seed  <= w_load_val;
    end else if (w_accept) begin
      if (bus.in_last) begin
        r_state <= r_seed;
      end else if (enable) begin
        r_state <= w_core_state;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= enable ? w_core_data : bus.in_data;
      r_out_last  <= bus.in_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  property p_hold_under_backpressure;
    @(posedge clock) disable iff (!reset_n)
      (r_out_valid && !bus.out_ready) |=>
        (r_out_valid && $stable(r_out_data) && $stable(r_out_last));
  endproperty

  a_hold_under_backpressure: assert property (p_hold_under_backpressure);

endmodule

// File: tb/tb_randomizer_par.sv
// Self-checking bench for randomizer_par: vector table, directed corner sequences, random scoreboard.
module tb_randomizer_par;

  localparam int unsigned LW    = 15;
  localparam int unsigned DW    = 8;
  localparam logic [14:0] TAP   = 15'h0003;
  localparam logic [14:0] DSEED = 15'h4A80;
`ifdef RANDOMIZER_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        load    = 1'b0;
  logic [14:0] seed    = '0;
  logic        enable  = 1'b1;
  logic        seed_err;

  randomizer_if #(.DATA_W(DW)) bus();

  randomizer_par #(
    .LFSR_W       (LW),
    .DATA_W       (DW),
    .TAP_MASK     (TAP),
    .DEFAULT_SEED (DSEED)
  ) dut (
    .clock    (clk),
    .reset_n  (rst_n),
    .load     (load),
    .seed     (seed),
    .enable   (enable),
    .bus      (bus),
    .seed_err (seed_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ld;
    logic [14:0] sd;
    logic        en;
    logic [7:0]  din;
    logic        lst;
    logic [7:0]  exp_d;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } obeat_t;

  vec_t   tbl[12];
  obeat_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Keystream model: each bit's key is the parity of the tapped state bits, which then
  // enters at the top while the register shifts toward bit 0.
  function automatic logic [7:0] ref_beat(input int unsigned st, input logic [7:0] d,
                                          output int unsigned st_next);
    int unsigned s;
    int unsigned fb;
    logic [7:0]  o;
    s = st;
    o = '0;
    for (int k = 0; k < 8; k++) begin
      fb   = $countones(s & 32'(TAP)) % 2;
      o[k] = d[k] ^ fb[0];
      s    = (s >> 1) + (fb << 14);
    end
    st_next = s;
    return o;
  endfunction

  task automatic beat(input string nm, input logic en, input logic [7:0] d, input logic lst,
                      input logic [7:0] exp_d, input logic exp_l);
    enable       = en;
    bus.in_data  = d;
    bus.in_last  = lst;
    bus.in_valid = 1'b1;
    #1 chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_out_data"},  32'(bus.out_data),  32'(exp_d));
    chk({nm, "_out_last"},  32'(bus.out_last),  32'(exp_l));
  endtask

  initial begin
    int unsigned st;
    int unsigned st2;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [7:0]  ev;
    int unsigned m_st;
    int unsigned m_seed;
    logic        m_ov;
    logic        m_rdy;
    logic        m_err;
    logic        acc;
    int unsigned nst;
    logic [14:0] lv;
    obeat_t      ob;

    tbl[0]  = '{1'b1, 15'h0001, 1'b1, 8'h00, 1'b0, 8'h01};
    tbl[1]  = '{1'b0, 15'h0000, 1'b1, 8'h00, 1'b1, 8'hC0};
    tbl[2]  = '{1'b0, 15'h0000, 1'b1, 8'h00, 1'b0, 8'h01};
    tbl[3]  = '{1'b0, 15'h0000, 1'b1, 8'h00, 1'b1, 8'hC0};
    tbl[4]  = '{1'b0, 15'h0000, 1'b0, 8'hA5, 1'b0, 8'hA5};
    tbl[5]  = '{1'b0, 15'h0000, 1'b1, 8'h00, 1'b0, 8'h01};
    tbl[6]  = '{1'b0, 15'h0000, 1'b1, 8'h00, 1'b1, 8'hC0};
    tbl[7]  = '{1'b0, 15'h0000, 1'b1, 8'hFF, 1'b0, 8'hFE};
    tbl[8]  = '{1'b0, 15'h0000, 1'b1, 8'h0F, 1'b1, 8'hCF};
    tbl[9]  = '{1'b0, 15'h0000, 1'b1, 8'h00, 1'b0, 8'h01};
    tbl[10] = '{1'b0, 15'h0000, 1'b0, 8'h3C, 1'b1, 8'h3C};
    tbl[11] = '{1'b0, 15'h0000, 1'b1, 8'h00, 1'b0, 8'h01};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_seed_err",  32'(seed_err),      32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_state",     32'(dut.r_state),   32'(DSEED));
    ev = ref_beat(32'(DSEED), 8'h00, st);
    beat("rst_first", 1'b1, 8'h00, 1'b1, ev, 1'b1);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].ld) begin
        load = 1'b1;
        seed = tbl[i].sd;
        @(negedge clk);
        load = 1'b0;
        #1;
      end
      beat($sformatf("tbl%0d", i), tbl[i].en, tbl[i].din, tbl[i].lst, tbl[i].exp_d, tbl[i].lst);
      if (i == 0) chk("state_after_beat1", 32'(dut.r_state), 32'h0080);
    end

    // Backpressure: one beat held five cycles, then released without loss or duplication
    @(negedge clk);
    load = 1'b1;
    seed = 15'h1234;
    @(negedge clk);
    load = 1'b0;
    st    = 32'h1234;
    exp_a = ref_beat(st, 8'h11, st2);
    exp_b = ref_beat(st2, 8'h22, st);
    bus.out_ready = 1'b0;
    enable        = 1'b1;
    bus.in_last   = 1'b0;
    bus.in_data   = 8'h11;
    bus.in_valid  = 1'b1;
    #1 chk("bp_accept_a", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_data = 8'h22;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data",  32'(bus.out_data),  32'(exp_a));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("bp_b_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_b_data",  32'(bus.out_data),  32'(exp_b));
    @(negedge clk);
    #1 chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // load while a beat is offered: not accepted that cycle, accepted next with new seed
    @(negedge clk);
    load         = 1'b1;
    seed         = 15'h2B5D;
    bus.in_data  = 8'h5A;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    #1 chk("ld_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    load = 1'b0;
    #1;
    chk("ld_no_accept", 32'(bus.out_valid), 32'd0);
    chk("ld_next_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    ev = ref_beat(32'h2B5D, 8'h5A, st);
    #1;
    chk("ld_out_valid", 32'(bus.out_valid), 32'd1);
    chk("ld_out_data",  32'(bus.out_data),  32'(ev));

    // Zero seed
    @(negedge clk);
    load = 1'b1;
    seed = '0;
    @(negedge clk);
    load = 1'b0;
    #1;
`ifdef RANDOMIZER_ZERO_GUARD_EN
    chk("zero_seed_err", 32'(seed_err), 32'd1);
    chk("zero_state",    32'(dut.r_state), 32'(DSEED));
    ev = ref_beat(32'(DSEED), 8'h96, st);
`else
    chk("zero_seed_err", 32'(seed_err), 32'd0);
    ev = 8'h96;
`endif
    beat("zero_beat", 1'b1, 8'h96, 1'b0, ev, 1'b0);

    // Reset mid-frame drops out_valid without a clock edge
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_data   = 8'h33;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("mid_out_valid", 32'(bus.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_err",   32'(seed_err),      32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    ev = ref_beat(32'(DSEED), 8'hC3, st);
    beat("mid_after_rst", 1'b1, 8'hC3, 1'b0, ev, 1'b0);

    // Random stimulus against the scoreboard
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_st   = 32'(DSEED);
    m_seed = 32'(DSEED);
    m_ov   = 1'b0;
    m_err  = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      load          = ($urandom_range(0, 29) == 0);
      seed          = ($urandom_range(0, 7) == 0) ? 15'h0000 : 15'($urandom);
      enable        = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_data   = 8'($urandom);
      bus.in_last   = ($urandom_range(0, 4) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_rdy = !load && (!m_ov || bus.out_ready);
      chk("rnd_in_ready",  32'(bus.in_ready),  32'(m_rdy));
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("rnd_seed_err",  32'(seed_err),      32'(m_err));
      if (m_ov) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_queue actual=empty required=one_beat");
        end else begin
          chk("rnd_out_data", 32'(bus.out_data), 32'(q[0].d));
          chk("rnd_out_last", 32'(bus.out_last), 32'(q[0].l));
          if (bus.out_ready) ob = q.pop_front();
        end
      end
      acc = bus.in_valid && m_rdy;
      if (load) begin
        lv = (GUARD && seed == '0) ? DSEED : seed;
        if (GUARD && seed == '0) m_err = 1'b1;
        m_st   = 32'(lv);
        m_seed = 32'(lv);
      end else if (acc) begin
        ob.d = ref_beat(m_st, bus.in_data, nst);
        if (!enable) ob.d = bus.in_data;
        ob.l = bus.in_last;
        q.push_back(ob);
        if (bus.in_last) m_st = m_seed;
        else if (enable) m_st = nst;
      end
      if (acc) m_ov = 1'b1;
      else if (bus.out_ready) m_ov = 1'b0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/randomizer_par.md
Name: randomizer_par

Overview:
- Parametrised successor to the serial energy-dispersal randomizer: Fibonacci LFSR scrambler, DATA_W bits per beat, programmable width and taps.
- Streaming block with valid/ready on both sides; automatic reseed at frame end; bypass mode.
- Sits between the framer and the FEC encoder in the TX datapath.

Parameters:
- LFSR_W, 15, LFSR register width.
- DATA_W, 8, data bits scrambled per accepted beat.
- TAP_MASK, 15'h0003, feedback taps: XOR of state bits selected by the mask.
- DEFAULT_SEED, 15'h4A80, seed held after reset.

Ports:
- clock, input, 1, single clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- load, input, 1, capture seed into seed register and LFSR state.
- seed, input, LFSR_W, seed value sampled when load=1.
- enable, input, 1, 1 = scramble; 0 = bypass, LFSR frozen.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept an input beat.
- in_data, input, DATA_W, input bits; bit 0 is first in serial order.
- in_last, input, 1, last beat of frame.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the output beat.
- out_data, output, DATA_W, scrambled data.
- out_last, output, 1, in_last delayed with its data.
- seed_err, output, 1, sticky all-zero-seed flag (optional feature only).

Behaviour:
- Clock/reset: one clock; reset is asynchronous, active-low (reset_n).
- Reset values:
  - state = seed_reg = DEFAULT_SEED.
  - out_valid = 0, out_data = 0, out_last = 0, seed_err = 0.
- Bit step, for k = 0..DATA_W-1 within one cycle:
  - s = XOR(state & TAP_MASK).
  - out_data[k] = in_data[k] ^ s.
  - state = {s, state[LFSR_W-1:1]}.
- Beat acceptance:
  - Accept when in_valid & in_ready.
  - in_ready = !load & (!out_valid | out_ready).
- Output register:
  - Latency 1 cycle from accept to out_valid.
  - out_valid clears on out_ready when no new accept occurs.
  - Output holds stable while out_valid & !out_ready.
- enable=0: out_data = in_data, state unchanged, handshake unchanged.
- enable is sampled per accepted beat; changing it mid-frame is legal and takes effect on the next beat.
- Frame end: after an accepted beat with in_last=1, state reloads from seed_reg, not from the stepped value. Applies even in bypass.
- load:
  - While load=1: seed_reg and state take seed; in_ready = 0, so no beat is accepted that cycle.
  - load has priority over any frame-end reseed.
  - The output register keeps draining during load.
- Reset mid-frame: out_valid drops immediately; the partial frame is lost; the next beat uses DEFAULT_SEED.
- Zero state without the optional feature: state stays zero and the output equals the input. This is the user's responsibility.

Optional Feature:
- Macro: RANDOMIZER_ZERO_GUARD_EN.
- Defined:
  - A load with seed == 0 stores DEFAULT_SEED into seed_reg and state.
  - seed_err is set, sticky until reset_n.
- Undefined:
  - Zero seed is loaded as-is.
  - seed_err is tied to 0.

Decomposition:
- Package randomizer_pkg holds:
  - Default constants: LFSR_W, DATA_W, TAP_MASK, DEFAULT_SEED.
  - Function lfsr_step(state, mask) returning the next state and feedback bit.
- One sub-module, randomizer_lfsr_core:
  - Combinational DATA_W-step unroll: state_in, data_in -> state_out, data_out.
  - The top level owns the registers and handshake.

Test Plan:
- Reset, then load seed=15'h0001, enable=1, in_data 8'h00 for two beats, out_ready=1 -> out_data 8'h01 then 8'hC0; state after beat 1 = 15'h0080.
- Send the same two-beat frame twice, with in_last=1 on beat 2, without reloading -> frame 2 output is identical to frame 1 (auto-reseed).
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> one beat held; in_ready=0; out_data stable; no beat lost or duplicated after release.
- enable=0, data 8'hA5 -> out 8'hA5, state unchanged; next enable=1 beat continues the original sequence.
- Assert load during an in_valid=1 beat -> in_ready=0 that cycle; beat accepted the next cycle with the new seed.
- Guard build: load seed=0 -> seed_err=1, state=15'h4A80. Non-guard build: output equals input.
- Assert reset_n mid-frame with out_valid=1 -> out_valid=0 asynchronously; first beat after reset uses DEFAULT_SEED.
